// File: rtl/apb_rr_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : apb_rr_master_arbiter
// Brief   : Round-robin arbiter that shares one APB completer between N_REQ
//           valid/ready requesters and drives the APB SETUP/ACCESS sequence.
// Revision: 1.0 - initial release
// ============================================================================
module apb_rr_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [N_REQ-1:0]                     req_valid_i,
    output logic [N_REQ-1:0]                     req_ready_o,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [N_REQ-1:0]                     req_write_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata_i,
    output logic [N_REQ-1:0]                     rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
    output logic                                 rsp_err_o,
    output logic [ADDR_WIDTH-1:0]                paddr_o,
    output logic                                 pwrite_o,
    output logic [DATA_WIDTH-1:0]                pwdata_o,
    output logic                                 psel_o,
    output logic                                 penable_o,
    input  logic [DATA_WIDTH-1:0]                prdata_i,
    input  logic                                 pready_i,
    input  logic                                 pslverr_i
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_PTR_W-1:0]      r_rr_ptr;
    logic [c_PTR_W-1:0]      r_owner;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic                    r_pwrite;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_psel;
    logic                    r_penable;
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    logic                    w_hi_found;
    logic [c_PTR_W-1:0]      w_hi_idx;
    logic                    w_found;
    logic [c_PTR_W-1:0]      w_lo_idx;
    logic [c_PTR_W-1:0]      w_winner;
    logic [c_PTR_W-1:0]      w_ptr_next;
    logic [N_REQ-1:0]        w_ready;

    // Lowest valid index at/above the pointer wins; otherwise the lowest valid overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_found    = 1'b0;
        w_lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                if (c_PTR_W'(i) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_PTR_W'(i);
                end
                w_found  = 1'b1;
                w_lo_idx = c_PTR_W'(i);
            end
        end
        w_winner   = w_hi_found ? w_hi_idx : w_lo_idx;
        w_ptr_next = (w_winner == c_LAST) ? '0 : w_winner + c_PTR_W'(1);
        w_ready    = '0;
        if ((r_state == S_IDLE) && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_paddr  <= req_addr_i[w_winner];
                        r_pwrite <= req_write_i[w_winner];
                        r_pwdata <= req_wdata_i[w_winner];
                        r_owner  <= w_winner;
                        r_rr_ptr <= w_ptr_next;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        r_rsp_rdata          <= prdata_i;
                        r_rsp_err            <= pslverr_i;
                        r_rsp_valid[r_owner] <= 1'b1;
                        r_psel               <= 1'b0;
                        r_penable            <= 1'b0;
                        r_state              <= S_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = w_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign paddr_o     = r_paddr;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;

`ifndef SYNTHESIS
    generate
        if (N_REQ < 1) begin : g_bad_n_req
            $error("apb_rr_master_arbiter: N_REQ must be >= 1");
        end
    endgenerate

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_ready_o));
    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(rsp_valid_o));
    a_access_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((r_state == S_ACCESS) && !pready_i) |=>
            ($stable(r_paddr) && $stable(r_pwrite) && $stable(r_pwdata)));
`endif

endmodule
`default_nettype wire
